dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. Accepts one load or store request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs a byte-enabled access on an internal word array, and returns read data plus an error flag over a valid/ready response channel. Serves as the target end of the load/store path when the core moves from a zero-latency data memory to a handshaked, multi-cycle one.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 50 +++++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int LAT_W     = 4;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = NUM_LANES * BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Expands per-byte enables into a full-width bit mask.
    function automatic logic [DATA_W-1:0] be_to_mask(input logic [NUM_LANES-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mask[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Word array with synchronous byte-enabled write, registered read
//            and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr_en,
    input  logic                 i_rd_en,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [NUM_LANES-1:0] i_be,
    output logic [DATA_W-1:0]    o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_mask;

    assign w_mask = be_to_mask(i_be);

    // Read register only moves on a read so the response stays stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wdata & w_mask);
            end
            if (i_rd_en) begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Handshaked, multi-cycle data-memory target with wait states.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [31:0]          i_req_addr,
    input  logic [DATA_W-1:0]    i_req_wdata,
    input  logic [NUM_LANES-1:0] i_req_be,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DATA_W-1:0]    o_rsp_rdata,
    output logic                 o_rsp_err
);

    localparam int          c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] c_DEPTH = 30'(DEPTH_WORDS);
    localparam logic [LAT_W-1:0] c_LAT = LAT_W'(LATENCY);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LAT_W-1:0]      r_cnt;
    logic                  r_live;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [NUM_LANES-1:0]  r_be;
    logic                  r_err;
    logic                  r_load_ok;

    logic                  w_accept;
    logic                  w_access;
    logic                  w_addr_err;
    logic                  w_arr_wr;
    logic                  w_arr_rd;
    logic [DATA_W-1:0]     w_arr_rdata;

    assign w_addr_err = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= c_DEPTH);
    assign w_arr_wr   = w_access &&  r_we && !w_addr_err;
    assign w_arr_rd   = w_access && !r_we && !w_addr_err;

    // r_live holds req_ready low until the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_req_ready = r_live;
                if (i_req_valid && r_live) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_err     <= 1'b0;
            r_load_ok <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_be    <= i_req_be;
                r_cnt   <= c_LAT;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_err     <= w_addr_err;
                r_load_ok <= !r_we && !w_addr_err;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_en (w_arr_wr),
        .i_rd_en (w_arr_rd),
        .i_idx   (r_addr[c_IDX_W+1:2]),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .o_rdata (w_arr_rdata)
    );

    // Stores and rejected accesses report zero data.
    assign o_rsp_rdata = (r_state == RESP && r_load_ok) ? w_arr_rdata : '0;
    assign o_rsp_err   = (r_state == RESP) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Randomized self-checking bench for dmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic [3:0]  i_req_be = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_be    (i_req_be),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    // Reference behaviour of one access against the word model.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, output logic [31:0] rd, output logic err);
        logic [31:0] mask;
        int          idx;
        rd  = '0;
        err = 1'b0;
        if (addr % 4 != 0 || (addr / 4) >= DEPTH) begin
            err = 1'b1;
        end else begin
            idx  = int'(addr / 4);
            mask = '0;
            for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
            if (we) mdl[idx] = (mdl[idx] & ~mask) | (wdata & mask);
            else    rd = mdl[idx];
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input string tag);
        logic [31:0] erd;
        logic        eerr;
        int          n;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_be    = be;
        n = 0;
        while (!o_req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!o_req_ready) begin
            check({tag, "_accept_timeout"}, 32'(o_req_ready), 32'd1);
            i_req_valid = 1'b0;
            return;
        end
        tick();
        model_access(we, addr, wdata, be, erd, eerr);
        // Garbage on the request bus while busy must be ignored.
        i_req_valid = 1'($urandom_range(0, 1));
        i_req_we    = 1'($urandom_range(0, 1));
        i_req_addr  = $urandom_range(0, 64) * 4;
        i_req_wdata = $urandom;
        i_req_be    = 4'($urandom_range(0, 15));
        n = 0;
        while (!o_rsp_valid && n < 40) begin
            i_rsp_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        i_rsp_ready = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        check({tag, "_rdata"}, o_rsp_rdata, erd);
        check({tag, "_err_rdy"}, {30'd0, o_rsp_err, o_req_ready}, {30'd0, eerr, 1'b0});
        i_req_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_ctl"}, {29'd0, o_rsp_valid, o_rsp_err, o_req_ready}, {29'd0, 1'b1, eerr, 1'b0});
            check({tag, "_hold_rdata"}, o_rsp_rdata, erd);
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check({tag, "_done"}, {30'd0, o_rsp_valid, o_req_ready}, 32'b01);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        model_clear();

        // Reset behaviour and first-edge release of req_ready.
        repeat (3) begin
            tick();
            check("rst_outs", {o_rsp_rdata[30:0] | {30'd0, o_req_ready}, o_rsp_valid},
                  32'd0);
            check("rst_err", 32'(o_rsp_err), 32'd0);
        end
        rst_n = 1'b1;
        check("rdy_before_edge", 32'(o_req_ready), 32'd0);
        tick();
        check("rdy_after_edge", 32'(o_req_ready), 32'd1);

        xact(1'b0, 32'h10, 32'h0, 4'hF, 0, "load_reset");
        xact(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, "store_full");
        xact(1'b0, 32'h40, 32'h0, 4'h0, 0, "load_full");
        xact(1'b1, 32'h40, 32'h11223344, 4'b0101, 0, "store_be5");
        xact(1'b0, 32'h40, 32'h0, 4'hF, 0, "load_be5");
        check("model_be5", mdl[16], 32'hDE22BE44);
        xact(1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 0, "store_be0");
        xact(1'b0, 32'h40, 32'h0, 4'hF, 0, "load_be0");
        xact(1'b0, 32'h42, 32'h0, 4'hF, 0, "load_misalign");
        xact(1'b1, 32'h400, 32'h12345678, 4'hF, 0, "store_oor");
        xact(1'b1, 32'h3FC, 32'hA5A5_5A5A, 4'hF, 0, "store_last");
        xact(1'b0, 32'h3FC, 32'h0, 4'hF, 0, "load_last");
        xact(1'b0, 32'h400, 32'h0, 4'hF, 5, "backpressure");
        xact(1'b0, 32'h40, 32'h0, 4'hF, 5, "bp_load");

        // Reset while the store is still waiting.
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 32'h80;
        i_req_wdata = 32'hCAFEF00D;
        i_req_be    = 4'hF;
        check("midrst_rdy", 32'(o_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_outs", {30'd0, o_rsp_valid, o_req_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        model_clear();
        tick();
        check("midrst_rdy_back", {30'd0, o_rsp_valid, o_req_ready}, 32'b01);
        xact(1'b0, 32'h80, 32'h0, 4'hF, 0, "midrst_load");
        xact(1'b0, 32'h40, 32'h0, 4'hF, 0, "cleared_load");

        // Randomized traffic over a small window to exercise read-after-write.
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 11);
            if (sel < 9)        a = $urandom_range(0, 7) * 4;
            else if (sel == 9)  a = $urandom_range(0, 7) * 4 + $urandom_range(1, 3);
            else if (sel == 10) a = 32'h400 + $urandom_range(0, 255) * 4;
            else                a = 32'h3FC;
            xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), "rand");
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
